// File: rtl/addsub_pkg.sv
// addsub_pkg: shared opcodes and state encoding for the add/subtract units
package addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
// ports: a, b, cin -> s, cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial two's-complement adder/subtractor
// ports: clk, rst_n, start/op/a/b request in; busy, done, sum/carry/overflow result out
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sa, sb;
  logic c, s, co, last;
  full_adder u_fa (.a(sa[0]), .b(sb[0]), .cin(c), .s(s), .cout(co));
  assign last = cnt == CW'(WIDTH - 1);
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  // result bits enter sa from the top as operand bits leave at the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      c <= 1'b0;
      sum <= '0;
      carry <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= op == OP_SUB ? ~b : b;
        c <= op;
        cnt <= '0;
      end
      if (state == RUN) begin
        sa <= {s, sa[WIDTH-1:1]};
        sb <= {1'b0, sb[WIDTH-1:1]};
        c <= co;
        cnt <= cnt + 1'b1;
        if (last) begin
          sum <= {s, sa[WIDTH-1:1]};
          carry <= co;
          overflow <= c ^ co;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub against an arithmetic reference model
module tb_serial_addsub;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, carry, overflow;
  int errors = 0, checks = 0;
  typedef struct packed {logic [W-1:0] s; logic c; logic v;} res_t;
  res_t q[$];
  res_t held = '0;
  res_t e;
  logic prev_done = 1'b0;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic res_t model(logic o, logic [W-1:0] x, logic [W-1:0] y);
    int ux, uy, sx, sy, r, sr;
    res_t m;
    ux = int'(x);
    uy = int'(y);
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    r = o ? ux - uy : ux + uy;
    sr = o ? sx - sy : sx + sy;
    m.s = r[W-1:0];
    m.c = o ? (ux >= uy) : (r >= (1 << W));
    m.v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return m;
  endfunction
  always @(posedge clk) begin
    #1;
    if (done) begin
      check("done_width", 32'(prev_done), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum=%0d with no pending op at %0t", sum, $time);
      end else begin
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("carry", 32'(carry), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        held = e;
      end
    end else if (busy) check("hold", 32'({sum, carry, overflow}), 32'(held));
    prev_done = done;
  end
  task automatic run_op(logic o, logic [W-1:0] x, logic [W-1:0] y, bit glitch = 1'b0);
    int lat, nb;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1;
    nb = busy ? 1 : 0;
    while (!done && lat < 12) begin
      if (glitch && lat == 1) begin
        start = 1'b1; a = 1; b = 1; op = 1'b0;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
      if (busy) nb++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 1);
    check("latency", lat, W + 1);
    check("busy_cycles", nb, W);
  endtask
  initial begin
    int idx[512];
    int j, t, nd;
    logic [8:0] v;
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({busy, done, sum, carry, overflow}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    run_op(1'b1, 4'd10, 4'd2);
    run_op(1'b1, 4'd15, 4'd2);
    run_op(1'b1, 4'd2, 4'd10);
    run_op(1'b0, 4'd7, 4'd1);
    run_op(1'b0, 4'd15, 4'd1);
    run_op(1'b0, 4'd3, 4'd4, 1'b1);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 4'd9; b = 4'd3;
    q.push_back(model(1'b0, 4'd9, 4'd3));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    q.delete();
    held = '0;
    #1;
    check("async_rst", 32'({busy, done, sum, carry, overflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_rst", nd, 0);
    run_op(1'b0, 4'd5, 4'd6);
    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = idx[i]; idx[i] = idx[j]; idx[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      v = 9'(idx[i]);
      run_op(v[8], v[7:4], v[3:0]);
    end
    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
